play_engine: RTL and testbench
==============================

# play_engine

Parametrised rhythm-game play engine: steps through a song one note at a time and judges player hits against each note's beat window. It accumulates saturating score and combo, and keeps a per-user high-score table. It sits between the song ROM, the key/hit front end, and the scoreboard display. It replaces the combinational play-mode logic with an explicit FSM, a configurable user count, and speed modes.

## Interface
Parameters:
- NOTE_KEYS, 7, number of note keys; goal and key vectors are one-hot of this width
- USERS, 4, high-score table entries; UW = $clog2(USERS)
- SCORE_W, 21, width of score, combo and table entries
- IDX_W, 8, song step index width

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a play
- abort  in  1  one-cycle pulse; cancels a play without commit
- user  in  UW  player index, latched on start
- speed  in  2  00/01 normal, 10 half time, 11 double time; latched on start
- beat_tick  in  1  one-cycle pulse per base beat
- song_len  in  IDX_W  number of notes in the song
- step_idx  out  IDX_W  ROM address of the current note
- goal_key  in  NOTE_KEYS  one-hot goal note at step_idx, combinational ROM
- goal_len  in  4  goal length in beats
- hit  in  1  one-cycle hit pulse
- key  in  NOTE_KEYS  one-hot key sampled with hit
- busy  out  1  high outside IDLE and DONE
- done  out  1  high while in DONE
- note_led  out  NOTE_KEYS  latched goal key during PLAY, else 0
- score, combo, max_combo  out  SCORE_W  running values
- hs_score  out  SCORE_W  table entry for the current user input
- new_record  out  1  one-cycle pulse when the table entry is raised

## Operation
- States: IDLE, LOAD, PLAY, SCORE, DONE.
- IDLE: start → LOAD. On start, clear score, combo, max_combo and step_idx; latch user and speed. If song_len=0, start → DONE instead.
- LOAD (1 cycle): latch goal_key and the window length W.
  - eff = max(goal_len, 1).
  - Normal: W = eff. Half time: W = 2·eff (5 bits). Double time: W = max(eff>>1, 1).
  - Clear elapsed count and the judged flag. Go to PLAY.
- PLAY: count beat_tick into elapsed.
  - The first hit is judged; later hits in the same window are ignored.
  - key==goal with elapsed=0 → PERFECT. key==goal with elapsed>0 → GOOD. key≠goal → MISS.
  - The window closes on the beat_tick that makes elapsed==W → SCORE. No judgement by then → MISS.
- SCORE (1 cycle):
  - PERFECT adds 100 + combo; GOOD adds 50 + combo. The add saturates at 2^SCORE_W−1.
  - PERFECT/GOOD increment combo (saturating); MISS clears combo.
  - max_combo = max(max_combo, new combo).
  - Then: step_idx+1 == song_len → DONE; else step_idx++ and → LOAD.
- DONE: on the entry cycle, if score > table[user_latched], write the entry and pulse new_record. Hold until start (new play, same as from IDLE) or abort → IDLE.
- abort in any state → IDLE next cycle. No table write; score/combo keep their values.
- start outside IDLE/DONE is ignored.

## Timing
- Reset: state IDLE, all outputs 0, every table entry 0. Applies mid-play too.
- start → busy high next cycle. goal_key is sampled one cycle after step_idx changes.
- Same cycle as the closing beat_tick, a hit is judged (GOOD or MISS, never PERFECT unless W=1 and elapsed=0).
- abort and start in the same cycle: abort wins.
- The last note's SCORE → DONE; new_record is asserted on the first DONE cycle only.
- hs_score is combinational from the table and the live user input.

## Configuration
- PLAY_ENGINE_AUTOPLAY_EN defined: adds input autoplay (1 bit).
  - When autoplay is high, each note is judged PERFECT at LOAD exit and PLAY still waits out the full window.
  - The table is never written and new_record stays 0 for that play; autoplay is latched on start.
- Undefined: no port; behaviour as above.

## Test plan
- Reset, song_len=3, all goal_len=1, speed 00, correct hit each window at elapsed 0 → score 100, 201, 303; combo 3; hs_score[user]=303; one new_record pulse.
- Speed 10, goal_len=2, correct hit after the 2nd tick → GOOD; window closes after 4 ticks; score 50.
- Wrong key, then correct key in the same window → MISS only; combo 0; second hit ignored.
- SCORE_W=8, long perfect run → score saturates at 255 and combo saturates.
- abort mid-PLAY → IDLE next cycle, table unchanged. Replay with a lower score → no new_record.
- song_len=0 start → DONE in one cycle, score 0, no table write.

Source files
------------

// File: rtl/play_engine.sv
// play_engine: steps a song note by note, judges hits against each beat window, keeps saturating
// score/combo and a per-user high-score table. Define PLAY_ENGINE_AUTOPLAY_EN for the autoplay input.
module play_engine #(
    parameter int unsigned NOTE_KEYS = 7,
    parameter int unsigned USERS     = 4,
    parameter int unsigned SCORE_W   = 21,
    parameter int unsigned IDX_W     = 8,
    localparam int unsigned UW       = (USERS > 1) ? $clog2(USERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
`ifdef PLAY_ENGINE_AUTOPLAY_EN
    input  logic                 autoplay,
`endif
    input  logic [UW-1:0]        user,
    input  logic [1:0]           speed,
    input  logic                 beat_tick,
    input  logic [IDX_W-1:0]     song_len,
    output logic [IDX_W-1:0]     step_idx,
    input  logic [NOTE_KEYS-1:0] goal_key,
    input  logic [3:0]           goal_len,
    input  logic                 hit,
    input  logic [NOTE_KEYS-1:0] key,
    output logic                 busy,
    output logic                 done,
    output logic [NOTE_KEYS-1:0] note_led,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   combo,
    output logic [SCORE_W-1:0]   max_combo,
    output logic [SCORE_W-1:0]   hs_score,
    output logic                 new_record
);

    localparam int unsigned SUM_W = SCORE_W + 2;

    typedef enum logic [2:0] {StIdle, StLoad, StPlay, StScore, StDone} state_e;
    typedef enum logic [1:0] {JudgeMiss, JudgeGood, JudgePerfect} judge_e;

    state_e               state_q;
    logic [UW-1:0]        user_q;
    logic [1:0]           speed_q;
    logic [NOTE_KEYS-1:0] goal_q;
    logic [4:0]           win_q;
    logic [4:0]           elapsed_q;
    logic                 judged_q;
    judge_e               judge_q;
    logic                 auto_q;
    logic [SCORE_W-1:0]   table_q [USERS];

`ifndef PLAY_ENGINE_AUTOPLAY_EN
    assign auto_q = 1'b0;
`endif

    logic [3:0]         eff;
    logic [4:0]         win_d;
    judge_e             hit_judge;
    judge_e             final_judge;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [SCORE_W-1:0] combo_nxt;
    logic [SCORE_W-1:0] max_nxt;
    logic               last_note;
    logic               user_ok;

    always_comb begin
        eff = (goal_len == 4'd0) ? 4'd1 : goal_len;
        case (speed_q)
            2'b10:   win_d = {eff, 1'b0};
            2'b11:   win_d = (eff[3:1] == 3'd0) ? 5'd1 : {2'b00, eff[3:1]};
            default: win_d = {1'b0, eff};
        endcase
    end

    always_comb begin
        hit_judge   = (key == goal_q) ? ((elapsed_q == 5'd0) ? JudgePerfect : JudgeGood) : JudgeMiss;
        final_judge = judged_q ? judge_q : JudgeMiss;
        sum = {2'b00, score} + {2'b00, combo}
            + ((final_judge == JudgePerfect) ? SUM_W'(100) : SUM_W'(50));
        score_nxt = score;
        combo_nxt = '0;
        if (final_judge != JudgeMiss) begin
            score_nxt = (sum[SUM_W-1:SCORE_W] != 2'b00) ? '1 : sum[SCORE_W-1:0];
            combo_nxt = (&combo) ? combo : combo + SCORE_W'(1);
        end
        max_nxt   = (combo_nxt > max_combo) ? combo_nxt : max_combo;
        last_note = ({1'b0, step_idx} + (IDX_W + 1)'(1)) == {1'b0, song_len};
        user_ok   = int'(user_q) < int'(USERS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            user_q     <= '0;
            speed_q    <= '0;
            goal_q     <= '0;
            win_q      <= '0;
            elapsed_q  <= '0;
            judged_q   <= 1'b0;
            judge_q    <= JudgeMiss;
            step_idx   <= '0;
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
            new_record <= 1'b0;
`ifdef PLAY_ENGINE_AUTOPLAY_EN
            auto_q     <= 1'b0;
`endif
            for (int i = 0; i < int'(USERS); i++) table_q[i] <= '0;
        end else begin
            new_record <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
            end else if (start && (state_q == StIdle || state_q == StDone)) begin
                user_q    <= user;
                speed_q   <= speed;
                step_idx  <= '0;
                score     <= '0;
                combo     <= '0;
                max_combo <= '0;
`ifdef PLAY_ENGINE_AUTOPLAY_EN
                auto_q    <= autoplay;
`endif
                state_q   <= (song_len == '0) ? StDone : StLoad;
            end else begin
                case (state_q)
                    StLoad: begin
                        goal_q    <= goal_key;
                        win_q     <= win_d;
                        elapsed_q <= '0;
                        // Autoplay pre-judges the note so player hits are ignored.
                        judged_q  <= auto_q;
                        judge_q   <= auto_q ? JudgePerfect : JudgeMiss;
                        state_q   <= StPlay;
                    end
                    StPlay: begin
                        if (hit && !judged_q) begin
                            judged_q <= 1'b1;
                            judge_q  <= hit_judge;
                        end
                        if (beat_tick) begin
                            elapsed_q <= elapsed_q + 5'd1;
                            if (elapsed_q + 5'd1 == win_q) state_q <= StScore;
                        end
                    end
                    StScore: begin
                        score     <= score_nxt;
                        combo     <= combo_nxt;
                        max_combo <= max_nxt;
                        if (last_note) begin
                            state_q <= StDone;
                            // Commit on the DONE entry edge so new_record lines up with its first cycle.
                            if (!auto_q && user_ok && score_nxt > table_q[user_q]) begin
                                table_q[user_q] <= score_nxt;
                                new_record      <= 1'b1;
                            end
                        end else begin
                            step_idx <= step_idx + IDX_W'(1);
                            state_q  <= StLoad;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);
    assign note_led = (state_q == StPlay) ? goal_q : '0;
    assign hs_score = (int'(user) < int'(USERS)) ? table_q[user] : '0;

endmodule

// File: tb/tb_play_engine.sv
// Self-checking bench for play_engine: two instances (SCORE_W 21 and 8) share stimulus and are
// compared against a note-level score/combo/high-score model.
module tb_play_engine;
    localparam int NK    = 7;
    localparam int USERS = 4;
    localparam int IDX_W = 8;
    localparam int UW    = 2;
    localparam int SWA   = 21;
    localparam int SWB   = 8;
    localparam longint MAXA = (64'd1 << SWA) - 1;
    localparam longint MAXB = (64'd1 << SWB) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, beat_tick, hit;
    logic [UW-1:0] user;
    logic [1:0] speed;
    logic [IDX_W-1:0] song_len;
    logic [NK-1:0] key;
    logic [NK-1:0] goal_key_a, goal_key_b;
    logic [3:0] goal_len_a, goal_len_b;
    logic [IDX_W-1:0] step_a, step_b;
    logic busy_a, done_a, nr_a, busy_b, done_b, nr_b;
    logic [NK-1:0] led_a, led_b;
    logic [SWA-1:0] score_a, combo_a, mc_a, hs_a;
    logic [SWB-1:0] score_b, combo_b, mc_b, hs_b;

    logic [NK-1:0] rom_key [256];
    logic [3:0]    rom_len [256];
    assign goal_key_a = rom_key[step_a];
    assign goal_len_a = rom_len[step_a];
    assign goal_key_b = rom_key[step_b];
    assign goal_len_b = rom_len[step_b];

    play_engine #(.NOTE_KEYS(NK), .USERS(USERS), .SCORE_W(SWA), .IDX_W(IDX_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef PLAY_ENGINE_AUTOPLAY_EN
        .autoplay(1'b0),
`endif
        .user(user), .speed(speed), .beat_tick(beat_tick), .song_len(song_len),
        .step_idx(step_a), .goal_key(goal_key_a), .goal_len(goal_len_a), .hit(hit), .key(key),
        .busy(busy_a), .done(done_a), .note_led(led_a), .score(score_a), .combo(combo_a),
        .max_combo(mc_a), .hs_score(hs_a), .new_record(nr_a)
    );

    play_engine #(.NOTE_KEYS(NK), .USERS(USERS), .SCORE_W(SWB), .IDX_W(IDX_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef PLAY_ENGINE_AUTOPLAY_EN
        .autoplay(1'b0),
`endif
        .user(user), .speed(speed), .beat_tick(beat_tick), .song_len(song_len),
        .step_idx(step_b), .goal_key(goal_key_b), .goal_len(goal_len_b), .hit(hit), .key(key),
        .busy(busy_b), .done(done_b), .note_led(led_b), .score(score_b), .combo(combo_b),
        .max_combo(mc_b), .hs_score(hs_b), .new_record(nr_b)
    );

    int n_cmp = 0;
    int n_fail = 0;
    longint sa, ca, xa, sb, cb, xb;
    longint hs_ma [USERS];
    longint hs_mb [USERS];

    function automatic int win(input int gl, input int spd);
        int eff;
        eff = (gl < 1) ? 1 : gl;
        if (spd == 2) return 2 * eff;
        if (spd == 3) return (eff / 2 < 1) ? 1 : eff / 2;
        return eff;
    endfunction

    task automatic tick(input bit t, input bit h, input logic [NK-1:0] k);
        beat_tick = t; hit = h; key = k;
        @(negedge clk);
        beat_tick = 1'b0; hit = 1'b0; key = '0;
    endtask

    task automatic fill_rom(input int len, input int maxgl, input int fixgl);
        for (int i = 0; i < len; i++) begin
            rom_key[i] = '0;
            rom_key[i][$urandom_range(0, NK - 1)] = 1'b1;
            rom_len[i] = (fixgl >= 0) ? 4'(fixgl) : 4'($urandom_range(0, maxgl));
        end
    endtask

    task automatic check_table();
        for (int u = 0; u < USERS; u++) begin
            user = UW'(u);
            #1;
            n_cmp++;
            if (hs_a !== SWA'(hs_ma[u]) || hs_b !== SWB'(hs_mb[u])) begin
                n_fail++;
                $display("FAIL hs_score user %0d: got %0d/%0d want %0d/%0d",
                         u, hs_a, hs_b, hs_ma[u], hs_mb[u]);
            end
        end
    endtask

    // fmode: -1 random, 0 no hit, 1 correct, 2 wrong, 3 correct on closing tick
    task automatic run_play(input int len, input int u, input int spd, input int fmode,
                            input int fe, input int fextra, input int abort_at);
        int w, mode, e, res, r;
        logic [NK-1:0] g, wrong, k2;
        bit exp_a, exp_b;
        song_len = IDX_W'(len); user = UW'(u); speed = 2'(spd); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sa = 0; ca = 0; xa = 0; sb = 0; cb = 0; xb = 0;
        user = UW'($urandom); speed = 2'($urandom);
        n_cmp++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start: got %b/%b want 1", busy_a, busy_b);
        end
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            g = rom_key[i];
            w = win(int'(rom_len[i]), spd);
            mode = (fmode >= 0) ? fmode : int'($urandom_range(0, 3));
            r = $urandom_range(1, NK - 1);
            wrong = (g << r) | (g >> (NK - r));
            if (i == abort_at) begin
                if (w > 1) tick(1'b1, 1'b0, '0);
                abort = 1'b1; start = 1'b1;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                n_cmp++;
                if (busy_a !== 1'b0 || done_a !== 1'b0 || score_a !== SWA'(sa)) begin
                    n_fail++;
                    $display("FAIL abort: got busy %b done %b score %0d want 0 0 %0d",
                             busy_a, done_a, score_a, sa);
                end
                check_table();
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            res = 0;
            if (mode == 1 || mode == 2) begin
                e = (fe >= 0) ? fe : int'($urandom_range(0, w - 1));
                for (int t = 0; t < e; t++) tick(1'b1, 1'b0, '0);
                tick(1'b0, 1'b1, (mode == 1) ? g : wrong);
                if (mode == 1) res = (e == 0) ? 2 : 1;
                if (fextra > 0 || (fextra < 0 && $urandom_range(0, 1) == 1)) begin
                    k2 = '0;
                    k2[$urandom_range(0, NK - 1)] = 1'b1;
                    tick(1'b0, 1'b1, (fextra > 0) ? g : k2);
                end
                for (int t = e; t < w - 1; t++) tick(1'b1, 1'b0, '0);
            end else begin
                for (int t = 0; t < w - 1; t++) tick(1'b1, 1'b0, '0);
                if (mode == 3) res = (w == 1) ? 2 : 1;
            end
            n_cmp++;
            if (led_a !== g) begin
                n_fail++; $display("FAIL window_open note %0d: led %b want %b", i, led_a, g);
            end
            tick(1'b1, mode == 3, g);
            n_cmp++;
            if (led_a !== '0) begin
                n_fail++; $display("FAIL window_closed note %0d: led %b want 0", i, led_a);
            end
            if (res > 0) begin
                sa = sa + ((res == 2) ? 100 : 50) + ca; if (sa > MAXA) sa = MAXA;
                sb = sb + ((res == 2) ? 100 : 50) + cb; if (sb > MAXB) sb = MAXB;
                ca = (ca + 1 > MAXA) ? MAXA : ca + 1;
                cb = (cb + 1 > MAXB) ? MAXB : cb + 1;
            end else begin
                ca = 0; cb = 0;
            end
            if (ca > xa) xa = ca;
            if (cb > xb) xb = cb;
            tick(1'b0, 1'b0, '0);
            n_cmp++;
            if (score_a !== SWA'(sa) || combo_a !== SWA'(ca) || mc_a !== SWA'(xa)) begin
                n_fail++;
                $display("FAIL score21 note %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, score_a, combo_a, mc_a, sa, ca, xa);
            end
            n_cmp++;
            if (score_b !== SWB'(sb) || combo_b !== SWB'(cb) || mc_b !== SWB'(xb)) begin
                n_fail++;
                $display("FAIL score8 note %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, score_b, combo_b, mc_b, sb, cb, xb);
            end
            if (i == len - 1) begin
                exp_a = sa > hs_ma[u];
                exp_b = sb > hs_mb[u];
                if (exp_a) hs_ma[u] = sa;
                if (exp_b) hs_mb[u] = sb;
                n_cmp++;
                if (done_a !== 1'b1 || nr_a !== exp_a || nr_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL done_entry: got done %b rec %b/%b want 1 %b/%b",
                             done_a, nr_a, nr_b, exp_a, exp_b);
                end
                tick(1'b0, 1'b0, '0);
                n_cmp++;
                if (done_a !== 1'b1 || nr_a !== 1'b0 || nr_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_hold: got done %b rec %b/%b want 1 0/0", done_a, nr_a, nr_b);
                end
            end else begin
                tick(1'b0, 1'b0, '0);
            end
        end
        check_table();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || score_a !== '0 || combo_a !== '0 ||
            mc_a !== '0 || step_a !== '0 || led_a !== '0 || nr_a !== 1'b0 || score_b !== '0) begin
            n_fail++;
            $display("FAIL reset: busy %b done %b score %0d combo %0d step %0d want all 0",
                     busy_a, done_a, score_a, combo_a, step_a);
        end
        for (int u = 0; u < USERS; u++) begin hs_ma[u] = 0; hs_mb[u] = 0; end
        check_table();
    endtask

    task automatic test_basic();
        fill_rom(3, 0, 1);
        run_play(3, 1, 0, 1, 0, 0, -1);
    endtask

    task automatic test_half_time();
        fill_rom(1, 0, 2);
        run_play(1, 0, 2, 1, 2, 0, -1);
    endtask

    task automatic test_wrong_then_right();
        fill_rom(1, 0, 3);
        run_play(1, 3, 0, 2, 0, 1, -1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(1, 8);
            fill_rom(len, 15, -1);
            run_play(len, $urandom_range(0, USERS - 1), $urandom_range(0, 3), -1, -1, -1, -1);
        end
    endtask

    task automatic test_saturation();
        fill_rom(255, 1, -1);
        run_play(255, 0, 0, 1, 0, 0, -1);
    endtask

    task automatic test_abort_replay();
        fill_rom(3, 0, 1);
        run_play(3, 2, 0, 1, 0, 0, -1);
        fill_rom(5, 4, -1);
        run_play(5, 2, $urandom_range(0, 3), -1, -1, -1, 2);
        fill_rom(2, 4, -1);
        run_play(2, 2, 0, 0, -1, 0, -1);
    endtask

    task automatic test_zero_len();
        song_len = '0; user = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || score_a !== '0 || nr_a !== 1'b0 || nr_b !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: got done %b busy %b score %0d rec %b want 1 0 0 0",
                     done_a, busy_a, score_a, nr_a);
        end
        check_table();
    endtask

    task automatic test_reset_mid();
        fill_rom(4, 3, -1);
        song_len = 8'd4; user = 2'd3; speed = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) tick(1'b1, 1'b0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || score_a !== '0 || step_a !== '0 || led_a !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy %b done %b score %0d step %0d want all 0",
                     busy_a, done_a, score_a, step_a);
        end
        for (int u = 0; u < USERS; u++) begin hs_ma[u] = 0; hs_mb[u] = 0; end
        check_table();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; beat_tick = 1'b0; hit = 1'b0;
        user = '0; speed = '0; song_len = '0; key = '0;
        for (int i = 0; i < 256; i++) begin rom_key[i] = 7'd1; rom_len[i] = 4'd1; end
        @(negedge clk);
        test_reset();
        test_basic();
        test_half_time();
        test_wrong_then_right();
        test_random();
        test_saturation();
        test_abort_replay();
        test_zero_len();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
